// File: rtl/nlc_pkg.sv
// nlc_pkg: shared NLC constants and the fp32 field layout
package nlc_pkg;
  localparam int FP32_EXP_BIAS = 127;
  localparam int FP32_MANT_W = 23;
  localparam int NLC_NUM_CH = 16;
  localparam int NLC_ADC_W = 21;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [FP32_MANT_W-1:0] mant;
  } fp32_t;
endpackage

// File: rtl/nlc_fix2flt_conv_if.sv
// nlc_fix2flt_conv_if: sample-in / float-out bundle between sequencer and converter
interface nlc_fix2flt_conv_if #(parameter int IN_W = 21, parameter int TAG_W = 4);
  logic srdyi;
  logic [IN_W-1:0] conv_input;
  logic srdyo;
  logic [31:0] conv_output;
  logic [TAG_W-1:0] tag_o;
  logic done;
  logic busy;
  logic ovf_err;
  modport master(output srdyi, conv_input, input srdyo, conv_output, tag_o, done, busy, ovf_err);
  modport slave(input srdyi, conv_input, output srdyo, conv_output, tag_o, done, busy, ovf_err);
endinterface

// File: rtl/nlc_lod.sv
// nlc_lod: leading-one detector returning the highest set bit position and a zero flag
module nlc_lod #(parameter int W = 21, parameter int PW = $clog2(W)) (
  input  logic [W-1:0]  a,
  output logic [PW-1:0] msb_pos,
  output logic          zero
);
  always_comb begin
    msb_pos = '0;
    for (int i = 0; i < W; i++) if (a[i]) msb_pos = PW'(i);
    zero = ~|a;
  end
endmodule

// File: rtl/nlc_fix2flt_conv.sv
// nlc_fix2flt_conv: 3-stage signed fixed-point to fp32 converter with per-frame channel tagging
module nlc_fix2flt_conv
  import nlc_pkg::*;
#(
  parameter int IN_W = NLC_ADC_W,
  parameter int FRAC_BITS = 0,
  parameter int NUM_CH = NLC_NUM_CH,
  parameter int TAG_W = $clog2(NUM_CH)
) (
  input logic clk,
  input logic rst,
  nlc_fix2flt_conv_if.slave io
);
  localparam int PW = $clog2(IN_W);
  if (IN_W > 24) begin : g_w_chk
    $error("IN_W above 24 cannot be converted exactly to fp32");
  end
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state_q, state_d;
  logic [TAG_W-1:0] idx_q, idx_d, tag1_q, tag1_d, tag2_q, tag2_d, tag3_q, tag3_d, tag_in;
  logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, s1_q, s1_d, s2_q, s2_d, z2_q, z2_d;
  logic done_q, done_d, ovf_q, ovf_d, acc, last, zero;
  logic [IN_W-1:0] mag1_q, mag1_d, mag2_q, mag2_d;
  logic [PW-1:0] pos, pos2_q, pos2_d;
  logic [7:0] e;
  logic [23:0] sh;
  fp32_t res;
  logic [31:0] out_q, out_d;
  nlc_lod #(.W(IN_W), .PW(PW)) u_lod (.a(mag1_q), .msb_pos(pos), .zero(zero));
  always_comb begin
    acc = io.srdyi && state_q != DRAIN;
    tag_in = state_q == IDLE ? '0 : idx_q;
    last = tag_in == TAG_W'(NUM_CH - 1);
    v1_d = acc;
    s1_d = io.conv_input[IN_W-1];
    mag1_d = s1_d ? -io.conv_input : io.conv_input;
    tag1_d = tag_in;
    v2_d = v1_q;
    s2_d = s1_q;
    mag2_d = mag1_q;
    pos2_d = pos;
    z2_d = zero;
    tag2_d = tag1_q;
    e = 8'(FP32_EXP_BIAS + int'(pos2_q) - FRAC_BITS);
    sh = 24'(mag2_q) << (FP32_MANT_W - int'(pos2_q));
    res = z2_q ? 32'h0 : {s2_q, e, sh[FP32_MANT_W-1:0]};
    v3_d = v2_q;
    out_d = v2_q ? res : out_q;
    tag3_d = v2_q ? tag2_q : tag3_q;
    done_d = state_q == DRAIN && v2_q && tag2_q == TAG_W'(NUM_CH - 1);
    ovf_d = ovf_q | (io.srdyi && state_q == DRAIN);
    state_d = done_d ? IDLE : acc ? (last ? DRAIN : RUN) : state_q;
    idx_d = acc ? (last ? '0 : tag_in + TAG_W'(1)) : idx_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      {v1_q, v2_q, v3_q, s1_q, s2_q, z2_q, done_q, ovf_q} <= '0;
      {tag1_q, tag2_q, tag3_q} <= '0;
      {mag1_q, mag2_q, pos2_q} <= '0;
      out_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      {v1_q, v2_q, v3_q, s1_q, s2_q, z2_q, done_q, ovf_q} <= {v1_d, v2_d, v3_d, s1_d, s2_d, z2_d, done_d, ovf_d};
      {tag1_q, tag2_q, tag3_q} <= {tag1_d, tag2_d, tag3_d};
      {mag1_q, mag2_q, pos2_q} <= {mag1_d, mag2_d, pos2_d};
      out_q <= out_d;
    end
  end
  assign io.srdyo = v3_q;
  assign io.conv_output = out_q;
  assign io.tag_o = tag3_q;
  assign io.done = done_q;
  assign io.busy = state_q != IDLE;
  assign io.ovf_err = ovf_q;
endmodule
